// File: rtl/filter_pkg.sv
// Shared types and default sizes for the filter scratchpad controller.
package filter_pkg;

   localparam int unsigned FILTER_WIDTH_D = 16;
   localparam int unsigned FILTER_ROW_D   = 12;
   localparam int unsigned WIN_W_D        = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SWEEP = 2'd2,
      DRAIN = 2'd3
   } fsp_state_t;

endpackage

// File: rtl/fsp_addr_cnt.sv
// Wrapping address counter: counts 0..limit_i on en_i, pulses wrap_o on the limit beat.
module fsp_addr_cnt #(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr_i,
   input  logic         en_i,
   input  logic [W-1:0] limit_i,
   output logic [W-1:0] cnt_o,
   output logic         wrap_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   assign wrap_o = en_i && (cnt_q == limit_i);
   assign cnt_o  = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)       cnt_d = '0;
      else if (wrap_o) cnt_d = '0;
      else if (en_i)   cnt_d = cnt_q + W'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end

endmodule

// File: rtl/filter_sp_ctrl.sv
// Filter scratchpad sequencer: loads one filter, then sweeps it num_windows times to the MAC.
// Optional sticky err output for rejected starts when FILTER_SP_CTRL_ERR_EN is defined.
module filter_sp_ctrl
   import filter_pkg::*;
#(
   parameter int unsigned FILTER_WIDTH = FILTER_WIDTH_D,
   parameter int unsigned FILTER_ROW   = FILTER_ROW_D,
   parameter int unsigned WIN_W        = WIN_W_D
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              start,
   input  logic [$clog2(FILTER_ROW+1)-1:0]   filt_size,
   input  logic [WIN_W-1:0]                  num_windows,
   input  logic [FILTER_WIDTH-1:0]           in_data,
   input  logic                              in_valid,
   output logic                              in_ready,
   output logic [FILTER_WIDTH-1:0]           sp_din,
   output logic [$clog2(FILTER_ROW)-1:0]     sp_waddr,
   output logic [$clog2(FILTER_ROW)-1:0]     sp_raddr,
   output logic                              sp_wen,
   output logic                              sp_ren,
   output logic                              sp_chip_en,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic                              out_last,
   output logic                              busy,
   output logic                              done
`ifdef FILTER_SP_CTRL_ERR_EN
   ,output logic                             err
`endif
);

   localparam int unsigned AW  = $clog2(FILTER_ROW);
   localparam int unsigned FSW = $clog2(FILTER_ROW + 1);

   fsp_state_t       state_q;
   logic [FSW-1:0]   fs_q;
   logic [WIN_W-1:0] nw_q;
   logic [WIN_W-1:0] wincnt_q;
   logic             out_valid_q;
   logic             out_last_q;
   logic             done_q;

   logic [AW-1:0]    wcnt;
   logic [AW-1:0]    rcnt;
   logic [AW-1:0]    limit;
   logic             wwrap;
   logic             rwrap;
   logic             issue;
   logic             start_ok;
   logic             last_win;

   assign limit    = AW'(fs_q - FSW'(1));
   assign start_ok = (filt_size != '0) && (filt_size <= FSW'(FILTER_ROW)) && (num_windows != '0);
   assign last_win = (wincnt_q == WIN_W'(nw_q - WIN_W'(1)));
   // A read may only be issued when the output register is free or draining this cycle.
   assign issue    = (state_q == SWEEP) && (!out_valid_q || out_ready);

   assign in_ready   = (state_q == LOAD);
   assign sp_wen     = in_ready && in_valid;
   assign sp_ren     = issue;
   assign sp_din     = in_data;
   assign sp_waddr   = wcnt;
   assign sp_raddr   = rcnt;
   assign sp_chip_en = (state_q != IDLE);
   assign busy       = (state_q != IDLE);
   assign out_valid  = out_valid_q;
   assign out_last   = out_last_q;
   assign done       = done_q;

   fsp_addr_cnt #(.W(AW)) u_wcnt (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (state_q == IDLE),
      .en_i    (sp_wen),
      .limit_i (limit),
      .cnt_o   (wcnt),
      .wrap_o  (wwrap)
   );

   fsp_addr_cnt #(.W(AW)) u_rcnt (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (state_q == IDLE),
      .en_i    (issue),
      .limit_i (limit),
      .cnt_o   (rcnt),
      .wrap_o  (rwrap)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         fs_q        <= '0;
         nw_q        <= '0;
         wincnt_q    <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         // Output register tracks the scratchpad's one-cycle read latency.
         if (issue) begin
            out_valid_q <= 1'b1;
            out_last_q  <= (rcnt == limit);
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
         end
         case (state_q)
            IDLE: begin
               if (start && start_ok) begin
                  fs_q     <= filt_size;
                  nw_q     <= num_windows;
                  wincnt_q <= '0;
                  state_q  <= LOAD;
               end
            end
            LOAD: begin
               if (wwrap) state_q <= SWEEP;
            end
            SWEEP: begin
               if (rwrap) begin
                  if (last_win) begin
                     wincnt_q <= '0;
                     state_q  <= DRAIN;
                  end else begin
                     wincnt_q <= wincnt_q + WIN_W'(1);
                  end
               end
            end
            DRAIN: begin
               if (out_valid_q && out_ready) begin
                  done_q  <= 1'b1;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef FILTER_SP_CTRL_ERR_EN
   logic err_q;
   assign err = err_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) err_q <= 1'b0;
      else if (start && ((state_q != IDLE) || !start_ok)) err_q <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_filter_sp_ctrl.sv
// Scoreboard bench for filter_sp_ctrl with a behavioural scratchpad and randomized jobs.
module tb_filter_sp_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [3:0]  filt_size;
   logic [7:0]  num_windows;
   logic [15:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] sp_din;
   logic [3:0]  sp_waddr;
   logic [3:0]  sp_raddr;
   logic        sp_wen;
   logic        sp_ren;
   logic        sp_chip_en;
   logic        out_valid;
   logic        out_ready;
   logic        out_last;
   logic        busy;
   logic        done;
`ifdef FILTER_SP_CTRL_ERR_EN
   logic        err;
`endif

   filter_sp_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .filt_size   (filt_size),
      .num_windows (num_windows),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .sp_din      (sp_din),
      .sp_waddr    (sp_waddr),
      .sp_raddr    (sp_raddr),
      .sp_wen      (sp_wen),
      .sp_ren      (sp_ren),
      .sp_chip_en  (sp_chip_en),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_last    (out_last),
      .busy        (busy),
      .done        (done)
`ifdef FILTER_SP_CTRL_ERR_EN
      ,.err        (err)
`endif
   );

   always #5 clk = ~clk;

   // Behavioural scratchpad: synchronous write, registered read, contents survive reset.
   logic [15:0] mem [16];
   logic [15:0] sp_dout;
   always @(posedge clk) begin
      if (sp_chip_en && sp_wen) mem[sp_waddr] <= sp_din;
      if (sp_chip_en && sp_ren) sp_dout <= mem[sp_raddr];
   end

   typedef struct {
      logic [15:0] data;
      logic        last;
      logic        fin;
   } exp_t;

   exp_t sb_q[$];
   int   tests_run    = 0;
   int   tests_failed = 0;
   int   popped       = 0;
   int   ready_mode   = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Output-ready pattern driver.
   int pi = 0;
   always begin
      @(posedge clk);
      #1;
      case (ready_mode)
         0: out_ready = 1'b1;
         1: out_ready = 1'($urandom_range(0, 1));
         default: begin
            out_ready = (pi == 0) || (pi == 3);
            pi = (pi + 1) % 4;
         end
      endcase
   end

   // Monitor: scoreboard pops, done timing, stall stability, write/read address rules.
   bit          exp_done  = 0;
   bit          prev_stall = 0;
   logic [15:0] prev_data;
   logic        prev_last;
   int          exp_waddr = 0;
   always @(negedge clk) begin
      if (!rst) begin
         exp_done   = 0;
         prev_stall = 0;
         exp_waddr  = 0;
      end else begin
         exp_t e;
         if (done || exp_done) chk("done_pulse", done, exp_done);
         exp_done = 0;
         if (sp_wen || sp_ren) chk("wen_ren_exclusive", sp_wen && sp_ren, 0);
         if (prev_stall) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_data", sp_dout, prev_data);
            chk("stall_last", out_last, prev_last);
         end
         if (!busy) exp_waddr = 0;
         if (sp_wen) begin
            chk("wen_on_handshake", in_valid && in_ready, 1);
            chk("waddr_contig", sp_waddr, exp_waddr);
            exp_waddr++;
         end
         if (sp_ren) chk("raddr_range", sp_raddr < 12, 1);
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_beat", sp_dout, 16'hdead);
            end else begin
               e = sb_q.pop_front();
               chk("out_data", sp_dout, e.data);
               chk("out_last", out_last, e.last);
               if (e.fin) exp_done = 1;
               popped++;
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = sp_dout;
         prev_last  = out_last;
      end
   end

   task automatic start_job(input int fs, input int nw, input bit gaps);
      logic [15:0] words [12];
      int i;
      int cyc;
      bit hs;
      for (int k = 0; k < fs; k++) words[k] = 16'($urandom_range(0, 16'hffff));
      for (int w = 0; w < nw; w++)
         for (int k = 0; k < fs; k++)
            sb_q.push_back('{words[k], (k == fs - 1), (w == nw - 1) && (k == fs - 1)});
      @(posedge clk); #1;
      filt_size   = 4'(fs);
      num_windows = 8'(nw);
      start       = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      i   = 0;
      cyc = 0;
      while (i < fs && cyc < 400) begin
         in_valid = gaps ? ((cyc % 2) == 0) : 1'b1;
         in_data  = words[i];
         @(negedge clk);
         hs = in_valid && in_ready;
         @(posedge clk); #1;
         if (hs) i++;
         cyc++;
      end
      in_valid = 1'b0;
      chk("load_beats", i, fs);
   endtask

   task automatic wait_done();
      int n = 0;
      while ((sb_q.size() != 0 || busy) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk("job_timeout", n < 3000, 1);
      repeat (2) @(negedge clk);
   endtask

   task automatic run_job(input int fs, input int nw, input bit gaps, input int rmode);
      ready_mode = rmode;
      start_job(fs, nw, gaps);
      wait_done();
      ready_mode = 0;
   endtask

   task automatic illegal_start(input int fs, input int nw);
      @(posedge clk); #1;
      filt_size   = 4'(fs);
      num_windows = 8'(nw);
      start       = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("illegal_busy", busy, 0);
         chk("illegal_in_ready", in_ready, 0);
      end
   endtask

   function automatic logic [7:0] out_vec();
      return {out_valid, out_last, done, sp_wen, sp_ren, sp_chip_en, busy, in_ready};
   endfunction

   initial begin
      rst         = 1'b0;
      start       = 1'b0;
      filt_size   = '0;
      num_windows = '0;
      in_data     = '0;
      in_valid    = 1'b0;
      out_ready   = 1'b1;
      #3;
      chk("reset_outputs", out_vec(), 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      // Fixed basic job with known words.
      begin
         int n;
         ready_mode = 0;
         sb_q.push_back('{16'h11, 1'b0, 1'b0});
         sb_q.push_back('{16'h22, 1'b0, 1'b0});
         sb_q.push_back('{16'h33, 1'b1, 1'b0});
         sb_q.push_back('{16'h11, 1'b0, 1'b0});
         sb_q.push_back('{16'h22, 1'b0, 1'b0});
         sb_q.push_back('{16'h33, 1'b1, 1'b1});
         @(posedge clk); #1;
         filt_size = 4'd3; num_windows = 8'd2; start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
         n = 0;
         for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data  = 16'((k + 1) * 16'h11);
            @(posedge clk); #1;
         end
         in_valid = 1'b0;
         wait_done();
      end

      run_job(12, 1, 1'b0, 0);          // full depth
      run_job(5, 2, 1'b0, 2);           // 1,0,0,1 backpressure
      run_job(7, 1, 1'b1, 0);           // load gaps

      // Start while busy is ignored.
      ready_mode = 1;
      start_job(5, 3, 1'b0);
      @(posedge clk); #1;
      filt_size = 4'd2; num_windows = 8'd1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done();
      ready_mode = 0;

      illegal_start(0, 2);
      illegal_start(13, 2);
      illegal_start(4, 0);
`ifdef FILTER_SP_CTRL_ERR_EN
      chk("err_sticky", err, 1);
`endif

      // Reset in the middle of a sweep, then a fresh job.
      begin
         int n = 0;
         popped = 0;
         start_job(4, 2, 1'b0);
         while (popped < 1 && n < 200) begin
            @(negedge clk);
            n++;
         end
         chk("reset_wait", n < 200, 1);
         #2;
         rst = 1'b0;
         #1;
         chk("midreset_outputs", out_vec(), 0);
         sb_q.delete();
         repeat (2) @(negedge clk);
         rst = 1'b1;
         run_job(4, 2, 1'b0, 0);
      end

      for (int j = 0; j < 8; j++)
         run_job(int'($urandom_range(1, 12)), int'($urandom_range(1, 4)),
                 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));

      chk("scoreboard_empty", sb_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/filter_sp_ctrl.md
# filter_sp_ctrl

Sequencing controller for the filter scratchpad of the convolution PE. It loads one filter of run-time length from an input stream into the scratchpad, then sweeps it out `num_windows` times as a valid/ready stream toward the MAC. It owns every scratchpad control pin: addresses, `ren`, `wen` and `chip_en`. It sits between the global-buffer read port and the PE multiplier.

## Interface
Parameters:
- FILTER_WIDTH, 16, filter word width
- FILTER_ROW, 12, scratchpad depth in words
- WIN_W, 8, width of the window-count input

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle job request; sampled only in IDLE
- filt_size  in  $clog2(FILTER_ROW+1)  words per filter; latched at start
- num_windows  in  WIN_W  sweep count; latched at start
- in_data  in  FILTER_WIDTH  filter word from the global buffer
- in_valid / in_ready  in / out  1  load handshake
- sp_din  out  FILTER_WIDTH  equals in_data (combinational)
- sp_waddr, sp_raddr  out  $clog2(FILTER_ROW)  scratchpad addresses
- sp_wen, sp_ren, sp_chip_en  out  1  scratchpad controls
- out_valid / out_ready  out / in  1  output stream; data is the scratchpad dout
- out_last  out  1  last word of the current sweep
- busy  out  1  high whenever the FSM is not in IDLE
- done  out  1  one-cycle pulse after the final word is accepted

## Operation
States and transitions:
- IDLE → LOAD on start when filt_size is in 1..FILTER_ROW and num_windows ≥ 1. Any other start is ignored.
- LOAD:
  - in_ready = 1.
  - Each in_valid & in_ready beat drives sp_wen = 1 and sp_waddr = wcnt; wcnt then increments.
  - On the beat where wcnt = filt_size−1, go to SWEEP; wcnt returns to 0.
- SWEEP:
  - Issue condition: !out_valid | out_ready. When it holds, drive sp_ren = 1 and sp_raddr = rcnt.
  - rcnt wraps from filt_size−1 to 0 and increments wincnt at the wrap.
  - After the read with rcnt = filt_size−1 and wincnt = num_windows−1, go to DRAIN.
- DRAIN: wait until the final out_valid & out_ready beat, then pulse done and return to IDLE.

Other rules:
- sp_chip_en = 1 in LOAD, SWEEP and DRAIN; 0 in IDLE. sp_wen and sp_ren are never both high.
- Counter widths: wcnt and rcnt are $clog2(FILTER_ROW); wincnt is WIN_W. All comparisons are against the latched copies of filt_size and num_windows.

## Timing
- Reset: out_valid, out_last, done, sp_wen, sp_ren, sp_chip_en, busy, in_ready are all 0. State is IDLE and all counters are 0.
- An asynchronous assertion of rst mid-job aborts immediately. Scratchpad contents are not touched.
- Read latency is 1 cycle: out_valid and out_last are registered in the cycle sp_ren is issued, so they align with dout.
- Stall: when out_valid & !out_ready, sp_ren stays 0. The scratchpad holds dout, and out_valid and out_last hold.
- Throughput is 1 word/cycle in LOAD and in SWEEP when there is no backpressure.
- LOAD→SWEEP: the first sp_ren is issued the cycle after the last write, so there is no read-before-write hazard.
- done occurs 1 cycle after the final accepted beat.
- start is ignored while busy.

## Configuration
- FILTER_SP_CTRL_ERR_EN defined:
  - Adds output `err` (1 bit, sticky, cleared only by rst).
  - err sets when start arrives in IDLE with filt_size = 0, filt_size > FILTER_ROW, or num_windows = 0.
  - err also sets when start arrives while busy.
  - Rejected starts are still ignored.
- FILTER_SP_CTRL_ERR_EN undefined: no err port; illegal starts are silently ignored.

## Structure
- Shared package `filter_pkg`:
  - state enum `fsp_state_t` (IDLE, LOAD, SWEEP, DRAIN)
  - default parameter constants FILTER_WIDTH_D and FILTER_ROW_D
- Natural sub-module `fsp_addr_cnt`: a wrapping counter with enable, limit input and wrap output. Instantiated for wcnt and for rcnt.
- The FSM and the output-valid register stay in the top module.

## Test plan
- Basic job: filt_size=3, num_windows=2, words 0x11,0x22,0x33, out_ready=1.
  - Output: 0x11,0x22,0x33,0x11,0x22,0x33.
  - out_last on the 3rd and 6th words; done exactly once.
- Full depth: filt_size=12, num_windows=1. Addresses 0..11 are written then read; no address exceeds 11.
- Backpressure: out_ready toggles 1,0,0,1 during a sweep. No word is lost or duplicated, and the output holds stable while stalled.
- Load gaps: in_valid is low every other cycle. sp_wen is only asserted on handshake beats, and waddr stays contiguous.
- Illegal start: filt_size=0 or 13 stays in IDLE with busy=0. With FILTER_SP_CTRL_ERR_EN, err=1.
- Reset mid-SWEEP: rst low during the 2nd word. All outputs go to 0 immediately; a fresh job afterwards completes correctly.
